// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4 constants and helpers for the RX classification path.
package eth_pkg;

  localparam int unsigned ETH_HDR_LEN = 14;
  localparam int unsigned IP_HDR_LEN  = 20;
  localparam int unsigned HDR_BYTES   = ETH_HDR_LEN + IP_HDR_LEN;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [7:0]  IP_PROTO_ICMP = 8'h01;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

  localparam logic [2:0] RTYPE_NONE = 3'b000;
  localparam logic [2:0] RTYPE_ARP  = 3'b001;
  localparam logic [2:0] RTYPE_UDP  = 3'b010;
  localparam logic [2:0] RTYPE_ICMP = 3'b100;

  // Byte idx (0 = first on the wire) of a 48-bit MAC address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    return 8'(mac >> (8 * (5 - 32'(idx))));
  endfunction

endpackage

// File: rtl/eth_hdr_buf.sv
// 20-byte write-once header store, replayed in order after classification.
module eth_hdr_buf
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic [4:0]  rd_idx,
  output logic        hdr_last,
  output logic [7:0]  ver_ihl,
  output logic [7:0]  proto,
  output logic [31:0] dst_ip
);

  localparam int unsigned IDX_W = 5;

  logic [IP_HDR_LEN-1:0][7:0] mem;
  logic [IDX_W-1:0]           wr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      hdr_last <= 1'b0;
    end else if (clr) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      hdr_last <= 1'b0;
    end else begin
      if (wr_en && (wr_idx < IDX_W'(IP_HDR_LEN))) begin
        mem[wr_idx] <= wr_data;
        wr_idx      <= wr_idx + IDX_W'(1);
        if (wr_idx == IDX_W'(IP_HDR_LEN - 1)) hdr_last <= wr_last;
      end
      if (rd_en && (rd_idx < IDX_W'(IP_HDR_LEN))) rd_idx <= rd_idx + IDX_W'(1);
    end
  end

  // rd_idx points at the next byte to load into the output register.
  assign rd_data = (rd_idx < IDX_W'(IP_HDR_LEN)) ? mem[rd_idx] : 8'h00;
  assign ver_ihl = mem[0];
  assign proto   = mem[9];
  assign dst_ip  = {mem[16], mem[17], mem[18], mem[19]};

endmodule

// File: rtl/eth_rx_classify.sv
// Strips the Ethernet header, filters ARP/UDP/ICMP for this host, re-emits from L3 onward.
module eth_rx_classify
  import eth_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_006E,
  parameter logic [47:0] LOCAL_MAC = 48'hABCD_1234_5678
) (
  input  logic        logic_clk,
  input  logic        logic_rstn,
  input  logic [7:0]  mac_rdata_in,
  input  logic        mac_rvalid_in,
  output logic        mac_rready_out,
  input  logic        mac_rlast_in,
  output logic [7:0]  net_rdata_out,
  output logic        net_rvalid_out,
  input  logic        net_rready_in,
  output logic        net_rlast_out,
  output logic [2:0]  net_rtype_out,
  output logic [15:0] drop_cnt_out
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned RD_W  = 5;
  localparam logic [CNT_W-1:0] ETH_LAST_IDX = CNT_W'(ETH_HDR_LEN - 1);
  localparam logic [CNT_W-1:0] HDR_LAST_IDX = CNT_W'(HDR_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, ETH_HDR, L3_HDR, DECIDE, HDR_OUT, PAYLOAD, DROP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ucast_q, bcast_q;
  logic [15:0]      etype_q;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [2:0]       rtype_q, rtype_d;
  logic             rready_q, rready_d;
  logic [15:0]      drop_cnt_q;
  logic             drop_inc;
  logic             buf_wr, buf_rd, buf_clr;

  logic [7:0]       buf_rd_data, buf_ver_ihl, buf_proto;
  logic [RD_W-1:0]  buf_rd_idx;
  logic             buf_hdr_last;
  logic [31:0]      buf_dst_ip;

  logic             mac_acc_c, net_hs_c, mac_ok_c, ip_ok_c;
  logic [2:0]       rtype_sel_c;

  eth_hdr_buf u_hdr_buf (
    .clk      (logic_clk),
    .rst_n    (logic_rstn),
    .clr      (buf_clr),
    .wr_en    (buf_wr),
    .wr_data  (mac_rdata_in),
    .wr_last  (mac_rlast_in),
    .rd_en    (buf_rd),
    .rd_data  (buf_rd_data),
    .rd_idx   (buf_rd_idx),
    .hdr_last (buf_hdr_last),
    .ver_ihl  (buf_ver_ihl),
    .proto    (buf_proto),
    .dst_ip   (buf_dst_ip)
  );

  // Payload is a straight pass-through; everything else comes from registers.
  assign mac_rready_out = (state_q == PAYLOAD) ? net_rready_in : rready_q;
  assign net_rdata_out  = (state_q == PAYLOAD) ? mac_rdata_in  : out_data_q;
  assign net_rvalid_out = (state_q == PAYLOAD) ? mac_rvalid_in : out_valid_q;
  assign net_rlast_out  = (state_q == PAYLOAD) ? mac_rlast_in  : out_last_q;
  assign net_rtype_out  = rtype_q;
  assign drop_cnt_out   = drop_cnt_q;

  assign mac_acc_c = mac_rvalid_in & mac_rready_out;
  assign net_hs_c  = net_rvalid_out & net_rready_in;
  assign mac_ok_c  = ucast_q | bcast_q;
  assign ip_ok_c   = mac_ok_c && (etype_q == ETH_TYPE_IP) &&
                     (buf_ver_ihl == IP_VER_IHL) && (buf_dst_ip == LOCAL_IP);

  always_comb begin
    rtype_sel_c = RTYPE_NONE;
    if (mac_ok_c && (etype_q == ETH_TYPE_ARP)) rtype_sel_c = RTYPE_ARP;
    else if (ip_ok_c && (buf_proto == IP_PROTO_UDP)) rtype_sel_c = RTYPE_UDP;
    else if (ip_ok_c && (buf_proto == IP_PROTO_ICMP)) rtype_sel_c = RTYPE_ICMP;
  end

  always_ff @(posedge logic_clk or negedge logic_rstn) begin
    if (!logic_rstn) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rtype_d     = rtype_q;
    drop_inc    = 1'b0;
    buf_wr      = 1'b0;
    buf_rd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mac_acc_c) begin
          if (mac_rlast_in) drop_inc = 1'b1;
          else              state_d  = ETH_HDR;
        end
      end
      ETH_HDR: begin
        if (mac_acc_c) begin
          if (mac_rlast_in) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end else if (cnt_q == ETH_LAST_IDX) begin
            state_d = L3_HDR;
          end
        end
      end
      L3_HDR: begin
        if (mac_acc_c) begin
          buf_wr = 1'b1;
          if (cnt_q == HDR_LAST_IDX) begin
            state_d = DECIDE;
          end else if (mac_rlast_in) begin
            drop_inc = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      DECIDE: begin
        if (rtype_sel_c != RTYPE_NONE) begin
          state_d     = HDR_OUT;
          rtype_d     = rtype_sel_c;
          out_valid_d = 1'b1;
          out_data_d  = buf_rd_data;
          out_last_d  = 1'b0;
          buf_rd      = 1'b1;
        end else begin
          drop_inc = 1'b1;
          state_d  = buf_hdr_last ? IDLE : DROP;
        end
      end
      HDR_OUT: begin
        if (net_hs_c) begin
          if (buf_rd_idx == RD_W'(IP_HDR_LEN)) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = 8'h00;
            state_d     = buf_hdr_last ? IDLE : PAYLOAD;
          end else begin
            out_data_d = buf_rd_data;
            out_last_d = buf_hdr_last && (buf_rd_idx == RD_W'(IP_HDR_LEN - 1));
            buf_rd     = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (mac_acc_c && mac_rlast_in) state_d = IDLE;
      end
      DROP: begin
        if (mac_acc_c && mac_rlast_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) rtype_d = RTYPE_NONE;
  end

  // Input ready is registered from the next state; payload overrides it combinationally.
  assign rready_d = (state_d == IDLE) || (state_d == ETH_HDR) ||
                    (state_d == L3_HDR) || (state_d == DROP);
  assign buf_clr  = (state_d == IDLE);
  assign cnt_d    = (state_d == IDLE) ? '0 :
                    (mac_acc_c && (cnt_q != HDR_LAST_IDX)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge logic_clk or negedge logic_rstn) begin
    if (!logic_rstn) begin
      cnt_q       <= '0;
      ucast_q     <= 1'b0;
      bcast_q     <= 1'b0;
      etype_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      rtype_q     <= RTYPE_NONE;
      rready_q    <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      rtype_q     <= rtype_d;
      rready_q    <= rready_d;
      if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
      // Destination MAC matching runs against both targets in parallel.
      if (mac_acc_c && (state_q == IDLE)) begin
        ucast_q <= (mac_rdata_in == mac_byte(LOCAL_MAC, 3'd0));
        bcast_q <= (mac_rdata_in == mac_byte(MAC_BCAST, 3'd0));
      end else if (mac_acc_c && (state_q == ETH_HDR)) begin
        if (cnt_q < CNT_W'(6)) begin
          ucast_q <= ucast_q & (mac_rdata_in == mac_byte(LOCAL_MAC, cnt_q[2:0]));
          bcast_q <= bcast_q & (mac_rdata_in == mac_byte(MAC_BCAST, cnt_q[2:0]));
        end
        if (cnt_q == CNT_W'(12)) etype_q[15:8] <= mac_rdata_in;
        if (cnt_q == CNT_W'(13)) etype_q[7:0]  <= mac_rdata_in;
      end
    end
  end

endmodule
